// File: rtl/res_tbl_access_arbiter.sv
// Serialises alloc/dealloc requests into single-op transactions on resource_table_group.
// Optional WAIT timeout is built when RES_TBL_ARB_TIMEOUT_EN is defined.
module res_tbl_access_arbiter #(
    parameter int STARVE_LIMIT   = 8,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int WG_ID_WIDTH    = 8,
    parameter int SUB_CU_WIDTH   = 2,
    parameter int LDS_WIDTH      = 10,
    parameter int VGPR_WIDTH     = 9,
    parameter int SGPR_WIDTH     = 9,
    parameter int WF_WIDTH       = 5,
    parameter int WG_COUNT_WIDTH = 5,
    localparam int ID_WIDTH    = WG_ID_WIDTH + SUB_CU_WIDTH,
    localparam int INFO_WIDTH  = ID_WIDTH + 2 * (LDS_WIDTH + VGPR_WIDTH + SGPR_WIDTH) + WF_WIDTH,
    localparam int SPACE_WIDTH = 2 * (LDS_WIDTH + VGPR_WIDTH + SGPR_WIDTH) + WF_WIDTH + WG_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_valid_i,
    output logic                   alloc_ready_o,
    input  logic [INFO_WIDTH-1:0]  alloc_info_i,
    input  logic                   dealloc_valid_i,
    output logic                   dealloc_ready_o,
    input  logic [ID_WIDTH-1:0]    dealloc_info_i,
    output logic                   grp_alloc_en_o,
    output logic                   grp_dealloc_en_o,
    output logic [INFO_WIDTH-1:0]  grp_info_o,
    input  logic                   grp_done_i,
    input  logic [SPACE_WIDTH-1:0] grp_space_i,
    output logic                   grp_done_cancelled_o,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic                   resp_is_alloc_o,
    output logic [SPACE_WIDTH-1:0] resp_space_o,
    output logic                   resp_err_o,
    output logic                   err_timeout_o,
    output logic [2:0]             dbg_state
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both high;
    // valid may drop without a transfer, and ready is only offered to the IDLE winner.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ACK   = 3'd4
    } state_t;

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int PAD_W    = INFO_WIDTH - ID_WIDTH;

    if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("res_tbl_access_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be >= 1");
    end

    state_t              state, state_next;
    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_sat;
    logic                alloc_win, dealloc_win;
    logic                alloc_go, dealloc_go;
    logic                timeout_hit;

    assign starve_sat = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign dbg_state  = state;

    always_comb begin
        state_next      = state;
        alloc_win       = alloc_valid_i && (!dealloc_valid_i || starve_sat);
        dealloc_win     = dealloc_valid_i && !alloc_win;
        alloc_ready_o   = !rst && (state == IDLE) && alloc_win;
        dealloc_ready_o = !rst && (state == IDLE) && dealloc_win;
        alloc_go        = alloc_valid_i && alloc_ready_o;
        dealloc_go      = dealloc_valid_i && dealloc_ready_o;
        resp_valid_o    = (state == RESP);
        case (state)
            IDLE:    if (alloc_go || dealloc_go) state_next = ISSUE;
            // done seen here may belong to the previous op, so it is not sampled
            ISSUE:   state_next = WAIT;
            WAIT:    if (grp_done_i || timeout_hit) state_next = RESP;
            RESP:    if (resp_ready_i) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            starve_cnt           <= '0;
            grp_info_o           <= '0;
            resp_is_alloc_o      <= 1'b0;
            grp_alloc_en_o       <= 1'b0;
            grp_dealloc_en_o     <= 1'b0;
            grp_done_cancelled_o <= 1'b0;
            resp_space_o         <= '0;
        end else begin
            state                <= state_next;
            grp_alloc_en_o       <= alloc_go;
            grp_dealloc_en_o     <= dealloc_go;
            grp_done_cancelled_o <= (state == RESP) && resp_ready_i;
            if (alloc_go) begin
                grp_info_o      <= alloc_info_i;
                resp_is_alloc_o <= 1'b1;
                starve_cnt      <= '0;
            end else if (dealloc_go) begin
                grp_info_o      <= {dealloc_info_i, {PAD_W{1'b0}}};
                resp_is_alloc_o <= 1'b0;
                if (alloc_valid_i && !starve_sat) starve_cnt <= starve_cnt + 1'b1;
            end
            if (state == WAIT) begin
                if (grp_done_i) resp_space_o <= grp_space_i;
                else if (timeout_hit) resp_space_o <= '0;
            end
        end
    end

`ifdef RES_TBL_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              resp_err_q;
    logic              err_timeout_q;

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle, i.e. as the counter reaches the limit.
    assign timeout_hit = (state == WAIT) && !grp_done_i &&
                         (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt      <= '0;
            resp_err_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            if (state == ISSUE) wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            if ((state == WAIT) && grp_done_i) begin
                resp_err_q <= 1'b0;
            end else if (timeout_hit) begin
                resp_err_q    <= 1'b1;
                err_timeout_q <= 1'b1;
            end
        end
    end

    assign resp_err_o    = resp_err_q;
    assign err_timeout_o = err_timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign resp_err_o    = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

endmodule

// File: doc/res_tbl_access_arbiter.md
# res_tbl_access_arbiter

Sequencer and arbiter in front of `resource_table_group`. It takes workgroup allocation requests from the CTA allocator and deallocation requests from the CU completion path, and serialises them into single-cycle `alloc_en`/`dealloc_en` pulses. After each pulse it waits for `res_tbl_done`, returns the post-operation free-space snapshot to the requester, then acknowledges the group with `done_cancelled`. Only one operation is ever in flight in the group.

## Interface
- `STARVE_LIMIT`, default 8: consecutive cycles a pending alloc may lose to dealloc before alloc is forced to win.
- `TIMEOUT_CYCLES`, default 1023: maximum cycles spent in WAIT before a timeout is declared. Only used when the timeout feature is enabled.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alloc_valid_i` / `alloc_ready_o` in/out 1: alloc request handshake.
- `alloc_info_i` in packed: {wg_id, sub_cu_id, lds_start, lds_size, vgpr_start, vgpr_size, sgpr_start, sgpr_size, wf_count}, MSB first. Each field uses the group's port widths.
- `dealloc_valid_i` / `dealloc_ready_o` in/out 1: dealloc request handshake.
- `dealloc_info_i` in `WG_ID_WIDTH`+sub-CU width: {wg_id, sub_cu_id}.
- `grp_alloc_en_o`, `grp_dealloc_en_o` out 1: registered one-cycle pulses to the group.
- `grp_info_o` out packed: fields latched at acceptance. Size, start and wf_count fields are zero for a dealloc.
- `grp_done_i` in 1: `res_tbl_done_o` from the group.
- `grp_space_i` in packed: {lds_start, lds_size, vgpr_start, vgpr_size, sgpr_start, sgpr_size, wf_count, wg_count} from the group.
- `grp_done_cancelled_o` out 1: registered one-cycle pulse to the group.
- `resp_valid_o` / `resp_ready_i` out/in 1: response handshake.
- `resp_is_alloc_o` out 1: response belongs to an alloc (1) or a dealloc (0).
- `resp_space_o` out = `grp_space_i` width: snapshot captured in the cycle `grp_done_i` is seen.
- `resp_err_o` out 1: response terminated by timeout.
- `err_timeout_o` out 1: sticky timeout flag, cleared only by `rst`.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP, ACK.
- **IDLE**
  - `alloc_ready_o`/`dealloc_ready_o` are high only in IDLE, and only for the arbitration winner.
  - Dealloc wins when both are valid, unless `starve_cnt == STARVE_LIMIT`, in which case alloc wins.
  - On handshake: latch info and op type, go to ISSUE.
- **ISSUE** (1 cycle): `grp_alloc_en_o` or `grp_dealloc_en_o` = 1. Go to WAIT. `grp_done_i` is ignored in this cycle, because it may be stale from the previous op.
- **WAIT**: on `grp_done_i` = 1, capture `grp_space_i` into `resp_space_o`, set `resp_err_o` = 0, go to RESP.
- **RESP**: `resp_valid_o` = 1, with all resp outputs held stable. On `resp_ready_i`, go to ACK.
- **ACK** (1 cycle): `grp_done_cancelled_o` = 1, go to IDLE.
- **starve_cnt** (width clog2(STARVE_LIMIT+1)):
  - Increments, saturating at STARVE_LIMIT, each IDLE cycle in which `alloc_valid_i` is high and dealloc is granted.
  - Clears on alloc grant.
  - Holds in all other cycles.
- `grp_info_o` holds its value from acceptance until the next acceptance.

## Timing
- Reset values: all outputs 0, `grp_info_o` = 0, `resp_space_o` = 0, state IDLE, `starve_cnt` = 0.
- Latency:
  - Handshake at cycle A; en pulse at A+1; WAIT from A+2.
  - `grp_done_i` first seen at cycle D gives `resp_valid_o` = 1 at D+1.
  - Response handshake at cycle R gives `done_cancelled` at R+1 and IDLE (ready) at R+2.
- Back-to-back throughput: one op per (group latency + 4) cycles, minimum.
- Requester `valid` may drop without a handshake. No state change results.
- Reset mid-operation:
  - Returns the FSM to IDLE immediately and suppresses any pending pulse.
  - The group is not reset by this block. The integrator must reset both together.

## Configuration
- `RES_TBL_ARB_TIMEOUT_EN` defined:
  - A WAIT counter (width clog2(TIMEOUT_CYCLES+1)) clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without `grp_done_i`, the block goes to RESP with `resp_err_o` = 1, `resp_space_o` = 0, and `err_timeout_o` set.
  - ACK still pulses `grp_done_cancelled_o`.
- `RES_TBL_ARB_TIMEOUT_EN` undefined:
  - WAIT persists until `grp_done_i`.
  - `resp_err_o` and `err_timeout_o` are tied 0.
  - No counter is built.

## Test plan
- **Single alloc.** Alloc wg_id=5, vgpr_size=64; model group raises done 6 cycles after en. Expect:
  - `grp_alloc_en_o` exactly one cycle at A+1.
  - `resp_valid_o` at D+1 with the captured snapshot and `resp_is_alloc_o` = 1.
  - `grp_done_cancelled_o` pulse at R+1.
- **Simultaneous requests.** Alloc and dealloc valid in the same cycle. Expect dealloc granted first (`grp_dealloc_en_o`, size fields 0) and alloc granted on the next IDLE.
- **Starvation.** STARVE_LIMIT=2; continuous dealloc stream plus one persistent alloc. Expect alloc granted on the 3rd arbitration.
- **Stale done.** Hold `grp_done_i` = 1 through the ISSUE cycle and drop it at ISSUE+1. Expect no response until done re-asserts.
- **Response backpressure.** `resp_ready_i` low 10 cycles. Expect `resp_valid_o` and `resp_space_o` held stable, no `done_cancelled`, both ready outputs 0.
- **Timeout and mid-op reset.** With `RES_TBL_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=20, never assert done. Expect `resp_err_o` = 1 after 20 WAIT cycles and `err_timeout_o` sticky. Then assert `rst` during WAIT of a new op. Expect all outputs 0 on the next cycle.
